// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the alu_seq sequencer.
//   op_t      - request op encoding (6..7 are illegal)
//   state_t   - sequencer states
//   ADD/SHL/SHR/NAND - command encodings of the 8-bit alu
//   MUL_ITERS - shift-add iterations of MUL8
//   op_legal  - whether an op is executable in this build (ALU_SEQ_MUL_EN)
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ADD16  = 3'd0,
    SUB16  = 3'd1,
    SHL16  = 3'd2,
    SHR16  = 3'd3,
    NAND16 = 3'd4,
    MUL8   = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    MUL,
    DONE
  } state_t;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SHL  = 3'b001;
  localparam logic [2:0] SHR  = 3'b010;
  localparam logic [2:0] NAND = 3'b011;

  localparam int unsigned MUL_ITERS = 8;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      ADD16, SUB16, SHL16, SHR16, NAND16: return 1'b1;
`ifdef ALU_SEQ_MUL_EN
      MUL8:                               return 1'b1;
`endif
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// alu: combinational DW-bit ALU with a serial carry in/out.
//   cmd  - ADD, SHL, SHR, NAND (alu_seq_pkg)
//   a, b - operands
//   sc_i - carry in (ADD) / bit shifted in (SHL, SHR)
//   y    - result
//   sc_o - carry out (ADD) / bit shifted out (SHL, SHR); 0 for NAND
module alu
  import alu_seq_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [2:0]    cmd,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sc_i,
  output logic [DW-1:0] y,
  output logic          sc_o
);

  always_comb begin
    y    = '0;
    sc_o = 1'b0;
    case (cmd)
      ADD:  {sc_o, y} = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, sc_i};
      SHL:  {sc_o, y} = {a, sc_i};
      SHR:  {y, sc_o} = {sc_i, a};
      NAND: y = ~(a & b);
      default: begin
        y    = '0;
        sc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer running 16-bit ops (and optionally an 8x8
// unsigned multiply) as byte passes through one shared 8-bit alu.
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only in IDLE)
//   req_op/a/b/cin        - op, 2*DW operands, carry-in (ADD16 only)
//   rsp_valid/rsp_ready   - response handshake; rsp_* held until accepted
//   rsp_result/carry/zero/parity/err - registered result and flags
// Build option: `define ALU_SEQ_MUL_EN builds the MUL8 datapath; without it
// MUL8 is rejected like any illegal op.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned OP_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [2*DW-1:0] req_a,
  input  logic [2*DW-1:0] req_b,
  input  logic            req_cin,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_result,
  output logic            rsp_carry,
  output logic            rsp_zero,
  output logic            rsp_parity,
  output logic            rsp_err
);

  state_t          state, state_d;
  logic [OP_W-1:0] op_q;
  logic [2*DW-1:0] a_q, b_q;
  logic            cin_q, carry_q;
  logic [DW-1:0]   lo_q;
  logic            req_illegal;

  logic [2:0]      alu_cmd;
  logic [DW-1:0]   alu_a, alu_b, alu_y;
  logic            alu_ci, alu_co;
  logic [2*DW-1:0] two_pass_res;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CNT_W = $clog2(MUL_ITERS);
  logic [2*DW-1:0] acc, acc_next;
  logic [DW-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic            mul_last;

  // {carry, sum, acc_lo} shifted right by one, truncated to 2*DW bits
  assign acc_next = {alu_co, alu_y, acc[DW-1:1]};
  assign mul_last = (cnt == CNT_W'(MUL_ITERS - 1));
`endif

  alu #(.DW(DW)) u_alu (
    .cmd  (alu_cmd),
    .a    (alu_a),
    .b    (alu_b),
    .sc_i (alu_ci),
    .y    (alu_y),
    .sc_o (alu_co)
  );

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == DONE);
  assign req_illegal = !op_legal(req_op);

  // SHR runs high byte first, so the first pass holds the upper result byte
  assign two_pass_res = (op_q == SHR16) ? {lo_q, alu_y} : {alu_y, lo_q};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    alu_cmd = ADD;
    alu_a   = '0;
    alu_b   = '0;
    alu_ci  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal) state_d = DONE;
`ifdef ALU_SEQ_MUL_EN
          else if (req_op == MUL8) state_d = MUL;
`endif
          else state_d = LO;
        end
      end
      LO: begin
        state_d = HI;
        case (op_q)
          ADD16: begin
            alu_a = a_q[DW-1:0]; alu_b = b_q[DW-1:0]; alu_ci = cin_q;
          end
          SUB16: begin
            alu_a = a_q[DW-1:0]; alu_b = ~b_q[DW-1:0]; alu_ci = 1'b1;
          end
          SHL16: begin
            alu_cmd = SHL; alu_a = a_q[DW-1:0];
          end
          SHR16: begin
            alu_cmd = SHR; alu_a = a_q[2*DW-1:DW];
          end
          NAND16: begin
            alu_cmd = NAND; alu_a = a_q[DW-1:0]; alu_b = b_q[DW-1:0];
          end
          default: ;
        endcase
      end
      HI: begin
        state_d = DONE;
        case (op_q)
          ADD16: begin
            alu_a = a_q[2*DW-1:DW]; alu_b = b_q[2*DW-1:DW]; alu_ci = carry_q;
          end
          SUB16: begin
            alu_a = a_q[2*DW-1:DW]; alu_b = ~b_q[2*DW-1:DW]; alu_ci = carry_q;
          end
          SHL16: begin
            alu_cmd = SHL; alu_a = a_q[2*DW-1:DW]; alu_ci = carry_q;
          end
          SHR16: begin
            alu_cmd = SHR; alu_a = a_q[DW-1:0]; alu_ci = a_q[DW];
          end
          NAND16: begin
            alu_cmd = NAND; alu_a = a_q[2*DW-1:DW]; alu_b = b_q[2*DW-1:DW];
          end
          default: ;
        endcase
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        alu_a = acc[2*DW-1:DW];
        alu_b = mplier[0] ? a_q[DW-1:0] : '0;
        if (mul_last) state_d = DONE;
      end
`endif
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      carry_q    <= 1'b0;
      lo_q       <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_parity <= 1'b0;
      rsp_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc        <= '0;
      mplier     <= '0;
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            cin_q <= req_cin;
            if (req_illegal) begin
              rsp_result <= '0;
              rsp_carry  <= 1'b0;
              rsp_zero   <= 1'b1;
              rsp_parity <= 1'b0;
              rsp_err    <= 1'b1;
            end
`ifdef ALU_SEQ_MUL_EN
            acc    <= '0;
            mplier <= req_b[DW-1:0];
            cnt    <= '0;
`endif
          end
        end
        LO: begin
          carry_q <= alu_co;
          lo_q    <= alu_y;
        end
        HI: begin
          carry_q    <= alu_co;
          rsp_result <= two_pass_res;
          rsp_carry  <= (op_q == NAND16) ? 1'b0 : alu_co;
          rsp_zero   <= (two_pass_res == '0);
          rsp_parity <= ^two_pass_res;
          rsp_err    <= 1'b0;
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            rsp_result <= acc_next;
            rsp_carry  <= 1'b0;
            rsp_zero   <= (acc_next == '0);
            rsp_parity <= ^acc_next;
            rsp_err    <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized bench for alu_seq; expected results
// come from plain 16-bit arithmetic on the request operands.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_zero, rsp_parity, rsp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        c, z, p, e;
    int          lat;
  } exp_t;

  alu_seq #(.DW(8), .OP_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_parity (rsp_parity),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin);
    exp_t m;
    int unsigned s;
    m.res = '0; m.c = 1'b0; m.e = 1'b0; m.lat = 3;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b) + int'(cin);
        m.res = 16'(s); m.c = (s > 32'hFFFF);
      end
      3'd1: begin m.res = a - b; m.c = (a >= b); end
      3'd2: begin m.res = a << 1; m.c = a[15]; end
      3'd3: begin m.res = a >> 1; m.c = a[0]; end
      3'd4: m.res = ~(a & b);
      3'd5: begin
`ifdef ALU_SEQ_MUL_EN
        m.res = 16'(a[7:0]) * 16'(b[7:0]); m.lat = 9;
`else
        m.e = 1'b1; m.lat = 1;
`endif
      end
      default: begin m.e = 1'b1; m.lat = 1; end
    endcase
    if (m.e) begin m.res = '0; m.c = 1'b0; end
    m.z = (m.res == 16'h0000);
    m.p = ^m.res;
    return m;
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input int hold);
    exp_t e;
    int   lat;
    int   w;
    e = model(op, a, b, cin);
    w = 0;
    while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
    chk({tag, "/ready_in"}, req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    req_cin = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "/latency"}, lat, e.lat);
    chk({tag, "/result"}, rsp_result, e.res);
    chk({tag, "/carry"}, rsp_carry, e.c);
    chk({tag, "/zero"}, rsp_zero, e.z);
    chk({tag, "/parity"}, rsp_parity, e.p);
    chk({tag, "/err"}, rsp_err, e.e);
    chk({tag, "/busy"}, req_ready, 0);
    // a request offered while the response waits must be ignored
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, rsp_valid, 1);
      chk({tag, "/hold_result"}, rsp_result, e.res);
      chk({tag, "/hold_flags"}, {rsp_carry, rsp_zero, rsp_parity, rsp_err},
          {e.c, e.z, e.p, e.e});
      chk({tag, "/hold_busy"}, req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "/released"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_cin = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/outputs", {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_parity, rsp_err}, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset/ready", {req_ready, rsp_valid}, 2'b10);

    do_op("add_12ff", 3'd0, 16'h12FF, 16'h0001, 1'b0, 0);
    do_op("sub_0100", 3'd1, 16'h0100, 16'h0001, 1'b0, 0);
    do_op("sub_0000", 3'd1, 16'h0000, 16'h0001, 1'b0, 0);
    do_op("shl_8001", 3'd2, 16'h8001, 16'h0000, 1'b0, 0);
    do_op("shr_8001", 3'd3, 16'h8001, 16'h0000, 1'b0, 0);
    do_op("nand_ffff", 3'd4, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    do_op("mul_ffff", 3'd5, 16'h00FF, 16'h00FF, 1'b0, 0);
    do_op("mul_zero", 3'd5, 16'h0000, 16'h0037, 1'b0, 0);
    do_op("add_cin_backp", 3'd0, 16'hFFFF, 16'h0000, 1'b1, 5);
    do_op("illegal7", 3'd7, 16'h1234, 16'h5678, 1'b1, 2);
    do_op("illegal6", 3'd6, 16'hAAAA, 16'h5555, 1'b0, 0);

    // reset while a MUL8 is in flight (iteration 4 when multiply is built)
    req_valid = 1'b1; req_op = 3'd5; req_a = 16'h00AB; req_b = 16'h00CD; req_cin = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset/state", {rsp_valid, req_ready}, 2'b01);
    do_op("add_after_reset", 3'd0, 16'h7FFF, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      do_op("random", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
            1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle sequencer that drives one instance of the team's 8-bit `alu` to execute 16-bit operations and an 8x8 unsigned multiply.
- It splits each request into byte passes, chains the ALU carry through a carry register, and assembles the 16-bit result and flags.
- It sits between the core's execute stage, the requester, and the ALU datapath.
- Interface is valid/ready on both the request and the response side; one operation is in flight at a time.

Parameters:
- DW, 8, ALU data width; operands and result are 2*DW bits. Only 8 is verified.
- OP_W, 3, width of the op field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high iff state==IDLE.
- req_op  in  OP_W  operation (encoding in package).
- req_a  in  2*DW  operand A; MUL8 uses A[DW-1:0].
- req_b  in  2*DW  operand B; MUL8 uses B[DW-1:0].
- req_cin  in  1  carry-in; used by ADD16 only.
- rsp_valid  out  1  result available; held until rsp_ready.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  2*DW  result.
- rsp_carry  out  1  final carry; see Behaviour.
- rsp_zero  out  1  rsp_result==0.
- rsp_parity  out  1  XOR-reduction of rsp_result.
- rsp_err  out  1  illegal op.

Behaviour:
- Reset: state=IDLE. rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_parity, rsp_err=0. Carry register=0.
- Reset mid-operation: the in-flight op and any pending response are discarded. req_ready=1 the cycle after reset deasserts.
- States: IDLE, LO, HI, MUL, DONE.
- IDLE: when req_valid&&req_ready, latch op/a/b/cin, then go to LO (two-pass ops), MUL (MUL8), or DONE with err=1 (illegal op).
- Request handshake at edge T. Two-pass ops: LO during T+1, HI during T+2, rsp_valid from T+3. MUL8: rsp_valid from T+9. Illegal op: rsp_valid from T+1.
- DONE: rsp_* registered and stable while rsp_valid=1. On rsp_ready, go to IDLE. No new request is accepted while in DONE.
- ADD16: LO uses ADD on A_lo,B_lo with sc_i=cin. HI uses ADD on A_hi,B_hi with sc_i=carry. rsp_carry = final carry-out.
- SUB16, computed as A+~B+1: LO uses ADD on A_lo,~B_lo with sc_i=1. HI uses ADD on A_hi,~B_hi with sc_i=carry. rsp_carry=1 means no borrow.
- SHL16: LO shifts A_lo left with sc_i=0, so carry=A_lo[7]. HI shifts A_hi left with sc_i=carry. rsp_carry=A_hi[7].
- SHR16: high byte first. LO state shifts A_hi right with sc_i=0. HI state shifts A_lo right with sc_i=A_hi[0]. rsp_carry=A_lo[0].
- NAND16: two NAND passes. rsp_carry=0.
- MUL8, shift-add over 8 iterations with an iteration counter 0..7:
  - Each cycle: {c,s} = ALU ADD(acc_hi, mplier[0] ? mcand : 0, sc_i=0).
  - Then acc <= {c,s,acc_lo}>>1 and mplier >>= 1.
  - After iteration 7, acc holds the 16-bit product. rsp_carry=0.
- Zero and parity are always computed over the full 2*DW result, never the last byte.
- rsp_err=1 forces rsp_result=0, rsp_carry=0, rsp_zero=1, rsp_parity=0.
- req_* values changing after the handshake have no effect.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL8 is supported as above.
- Undefined:
  - MUL state, counter and accumulator are not built.
  - op MUL8 is treated as illegal: rsp_err=1 with T+1 latency.

Decomposition:
- Package alu_seq_pkg holds:
  - op_t (3-bit): ADD16=0, SUB16=1, SHL16=2, SHR16=3, NAND16=4, MUL8=5; 6-7 illegal.
  - state_t.
  - ALU command constants: ADD=000, SHL=001, SHR=010, NAND=011.
  - MUL_ITERS=8.
- The single natural sub-module is the existing `alu`, instantiated once. The controller only muxes its inputs and latches its outputs.

Test Plan:
- ADD16 0x12FF+0x0001, cin=0 -> result 0x1300, carry 0, zero 0, rsp_valid exactly at T+3.
- SUB16 0x0100-0x0001 -> 0x00FF, carry 1. SUB16 0x0000-0x0001 -> 0xFFFF, carry 0, parity 0.
- SHL16 0x8001 -> 0x0002, carry 1. SHR16 0x8001 -> 0x4000, carry 1. NAND16 0xFFFF,0xFFFF -> 0x0000, zero 1.
- MUL8 0xFF*0xFF -> 0xFE01 at T+9. MUL8 0x00*0x37 -> 0x0000, zero 1. With the macro undefined, MUL8 -> err 1 at T+1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout. Op=7 -> err 1, result 0.
- Reset during MUL iteration 4 -> next cycle rsp_valid=0, req_ready=1. A following ADD16 completes correctly.
